// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one 8-bit ALU between two requesters with settle window and response handshake
module alu_rr_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data1,
  input  logic [7:0] req0_data2,
  input  logic [2:0] req0_select,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data1,
  input  logic [7:0] req1_data2,
  input  logic [2:0] req1_select,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_owner;
  logic [7:0] r_d1;
  logic [7:0] r_d2;
  logic [2:0] r_sel;
  logic [7:0] r_res;
  logic       r_err;
  logic       w_idle;
  logic       w_grant;
  logic       w_acc;
  logic [7:0] w_d1;
  logic [7:0] w_d2;
  logic [2:0] w_sel;
  logic       w_rsp_hs;
  // on contention the requester that did not win last time gets the grant
  assign w_idle     = r_state == IDLE;
  assign w_grant    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_acc      = req0_ready || req1_ready;
  assign w_d1       = w_grant ? req1_data1 : req0_data1;
  assign w_d2       = w_grant ? req1_data2 : req0_data2;
  assign w_sel      = w_grant ? req1_select : req0_select;
  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) && r_owner;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign rsp_result = r_res;
  assign rsp_err    = r_err;
  assign alu_data1  = r_d1;
  assign alu_data2  = r_d2;
  assign alu_select = r_sel;
  assign busy       = !w_idle;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_sel   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_owner <= w_grant;
          r_last  <= w_grant;
          // selects 4..7 never reach the ALU and answer immediately with an error
          if (w_sel[2]) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_d1    <= w_d1;
            r_d2    <= w_d2;
            r_sel   <= w_sel;
            r_cnt   <= 4'(SETTLE_CYCLES - 1);
            r_state <= EXEC;
          end
        end
        EXEC: if (r_cnt == 4'd0) begin
          r_res   <= alu_result;
          r_err   <= 1'b0;
          r_state <= RESP;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        RESP: if (w_rsp_hs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
